// File: rtl/movement_sequencer_if.sv
// Datapath-facing bundle of the movement sequencer: control code and PorB select out,
// datapath done/respawn flags and bird position in.
interface movement_sequencer_if;
  logic       enable;
  logic       leave;
  logic [7:0] xb;
  logic [7:0] yb;
  logic [3:0] control;
  logic       PorB;

  modport master (output control, output PorB, input enable, input leave, input xb, input yb);
  modport slave  (input control, input PorB, output enable, output leave, output xb, output yb);
endinterface

// File: rtl/movement_sequencer.sv
// Per-frame scheduler sharing one pixel datapath between crosshair and bird; owns bird behaviour.
// Optional WATCHDOG_EN: per-visit CLEAR/DRAW timeout that forces advance and sets sticky wd_err.
module movement_sequencer #(
  parameter int unsigned ESCAPE_FRAMES = 600,
  parameter int unsigned BIRD_STEPS    = 1,
  parameter int unsigned WD_CYCLES     = 64
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 frame_tick,
  input  logic                 btn_left,
  input  logic                 btn_right,
  input  logic                 btn_down,
  input  logic                 btn_up,
  input  logic                 shot,
  movement_sequencer_if.master dp,
  output logic                 fly,
  output logic                 fall,
  output logic                 frame_busy,
`ifdef WATCHDOG_EN
  output logic                 wd_err,
`endif
  output logic                 overrun
);

  localparam int unsigned ESC_W = $clog2(ESCAPE_FRAMES + 1);
  localparam int unsigned MV_W  = 4;

  localparam logic [3:0] CTL_HOLD  = 4'b0000;
  localparam logic [3:0] CTL_PRE   = 4'b0100;
  localparam logic [3:0] CTL_CLEAR = 4'b0001;
  localparam logic [3:0] CTL_LEFT  = 4'b0011;
  localparam logic [3:0] CTL_RIGHT = 4'b0010;
  localparam logic [3:0] CTL_DOWN  = 4'b0110;
  localparam logic [3:0] CTL_UP    = 4'b0111;
  localparam logic [3:0] CTL_DRAW  = 4'b0101;

  localparam logic [3:0] S_HOLD    = 4'd0;
  localparam logic [3:0] S_P_PRE   = 4'd1;
  localparam logic [3:0] S_P_CLEAR = 4'd2;
  localparam logic [3:0] S_P_MOVE  = 4'd3;
  localparam logic [3:0] S_P_DRAW  = 4'd4;
  localparam logic [3:0] S_B_PRE   = 4'd5;
  localparam logic [3:0] S_B_CLEAR = 4'd6;
  localparam logic [3:0] S_B_MOVE  = 4'd7;
  localparam logic [3:0] S_B_DRAW  = 4'd8;

  logic [3:0]       state_q, state_d;
  logic [3:0]       btn_q, btn_d;
  logic [MV_W-1:0]  mv_cnt_q, mv_cnt_d;
  logic [MV_W-1:0]  mv_len;
  logic [1:0]       mv_mode_q;
  logic             x_dir_q, y_dir_q;
  logic [ESC_W-1:0] esc_q;
  logic             first_q;
  logic [3:0]       mv_code, control_d;
  logic             porb_d;
  logic             enable_seen, visit_done;
  logic             normal;
  logic signed [7:0] yb_s;

  assign normal      = !fly && !fall;
  assign yb_s        = dp.yb;
  assign enable_seen = !first_q && dp.enable;
  assign mv_len      = (mv_mode_q == 2'b00) ? MV_W'(2 * BIRD_STEPS) : MV_W'(BIRD_STEPS);

  function automatic logic [3:0] btn_code(input logic [3:0] m);
    if (m[0]) return CTL_LEFT;
    if (m[1]) return CTL_RIGHT;
    if (m[2]) return CTL_DOWN;
    return CTL_UP;
  endfunction

  function automatic logic [3:0] lowest(input logic [3:0] m);
    return m & (~m + 4'd1);
  endfunction

  // mode is {fly, fall}; NORMAL alternates horizontal/vertical cycles
  function automatic logic [3:0] bird_code(input logic [1:0] mode, input logic xd,
                                           input logic yd, input logic [MV_W-1:0] idx);
    if (mode[0]) return CTL_DOWN;
    if (mode[1]) return CTL_UP;
    if (!idx[0]) return xd ? CTL_RIGHT : CTL_LEFT;
    return yd ? CTL_DOWN : CTL_UP;
  endfunction

`ifdef WATCHDOG_EN
  localparam int unsigned WD_W = $clog2(WD_CYCLES + 1);
  logic [WD_W-1:0] wd_cnt_q;
  logic            in_wait, wd_hit;

  assign in_wait    = state_q inside {S_P_CLEAR, S_P_DRAW, S_B_CLEAR, S_B_DRAW};
  assign wd_hit     = in_wait && !enable_seen && (wd_cnt_q == WD_W'(WD_CYCLES - 1));
  assign visit_done = enable_seen || wd_hit;

  // Cycle count within the current state visit; restarts on every state change
  always_ff @(posedge clk or negedge reset_n) begin : wd_regs
    if (!reset_n) begin
      wd_cnt_q <= '0;
      wd_err   <= 1'b0;
    end else begin
      wd_cnt_q <= (state_d != state_q) ? '0 : wd_cnt_q + WD_W'(1);
      if (wd_hit) wd_err <= 1'b1;
    end
  end
`else
  assign visit_done = enable_seen;
`endif

  // Next state plus the control code / select for the state being entered
  always_comb begin : fsm_next
    state_d   = state_q;
    btn_d     = btn_q;
    mv_cnt_d  = mv_cnt_q;
    mv_code   = CTL_HOLD;
    control_d = CTL_HOLD;
    porb_d    = 1'b0;
    case (state_q)
      S_HOLD: if (frame_tick) begin
        state_d = S_P_PRE;
        btn_d   = {btn_up, btn_down, btn_right, btn_left};
      end
      S_P_PRE: state_d = S_P_CLEAR;
      S_P_CLEAR: if (visit_done) begin
        if (btn_q != 4'd0) begin
          state_d = S_P_MOVE;
          mv_code = btn_code(btn_q);
        end else begin
          state_d = S_P_DRAW;
        end
      end
      S_P_MOVE: begin
        btn_d = btn_q & ~lowest(btn_q);
        if (btn_d != 4'd0) mv_code = btn_code(btn_d);
        else               state_d = S_P_DRAW;
      end
      S_P_DRAW: if (visit_done) state_d = S_B_PRE;
      S_B_PRE:  state_d = S_B_CLEAR;
      S_B_CLEAR: if (visit_done) begin
        state_d  = S_B_MOVE;
        mv_cnt_d = '0;
        mv_code  = bird_code(mv_mode_q, x_dir_q, y_dir_q, MV_W'(0));
      end
      S_B_MOVE: begin
        if (mv_cnt_q + MV_W'(1) < mv_len) begin
          mv_cnt_d = mv_cnt_q + MV_W'(1);
          mv_code  = bird_code(mv_mode_q, x_dir_q, y_dir_q, mv_cnt_d);
        end else begin
          state_d = S_B_DRAW;
        end
      end
      S_B_DRAW: if (visit_done) state_d = S_HOLD;
      default:  state_d = S_HOLD;
    endcase

    case (state_d)
      S_P_PRE, S_B_PRE:     control_d = CTL_PRE;
      S_P_CLEAR, S_B_CLEAR: control_d = CTL_CLEAR;
      S_P_MOVE, S_B_MOVE:   control_d = mv_code;
      S_P_DRAW, S_B_DRAW:   control_d = CTL_DRAW;
      default:              control_d = CTL_HOLD;
    endcase
    porb_d = state_d inside {S_B_PRE, S_B_CLEAR, S_B_MOVE, S_B_DRAW};
  end

  always_ff @(posedge clk or negedge reset_n) begin : fsm_regs
    if (!reset_n) begin
      state_q    <= S_HOLD;
      btn_q      <= '0;
      mv_cnt_q   <= '0;
      first_q    <= 1'b1;
      dp.control <= CTL_HOLD;
      dp.PorB    <= 1'b0;
      frame_busy <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      state_q    <= state_d;
      btn_q      <= btn_d;
      mv_cnt_q   <= mv_cnt_d;
      first_q    <= (state_d != state_q);
      dp.control <= control_d;
      dp.PorB    <= porb_d;
      frame_busy <= (state_d != S_HOLD);
      if (frame_tick && (state_q != S_HOLD)) overrun <= 1'b1;
    end
  end

  // Bird mode, bounce directions and escape timer; later assignments take priority
  always_ff @(posedge clk or negedge reset_n) begin : bird_regs
    if (!reset_n) begin
      x_dir_q   <= 1'b1;
      y_dir_q   <= 1'b0;
      esc_q     <= '0;
      fly       <= 1'b0;
      fall      <= 1'b0;
      mv_mode_q <= 2'b00;
    end else begin
      if (state_q == S_B_PRE) begin
        mv_mode_q <= {fly, fall};
        if (normal) begin
          if (dp.xb <= 8'd2)        x_dir_q <= 1'b1;
          else if (dp.xb >= 8'd158) x_dir_q <= 1'b0;
          if (yb_s <= 8'sd0)        y_dir_q <= 1'b1;
          else if (yb_s >= 8'sd117) y_dir_q <= 1'b0;
        end
      end
      if (normal && (state_q == S_B_DRAW) && (state_d == S_HOLD)) begin
        if (esc_q == ESC_W'(ESCAPE_FRAMES - 1)) begin
          fly   <= 1'b1;
          esc_q <= '0;
        end else begin
          esc_q <= esc_q + ESC_W'(1);
        end
      end
      if (normal && shot) begin
        fall  <= 1'b1;
        fly   <= 1'b0;
        esc_q <= '0;
      end
      if (dp.leave && (state_q == S_B_DRAW)) begin
        fly   <= 1'b0;
        fall  <= 1'b0;
        esc_q <= '0;
      end
    end
  end

endmodule

// File: tb/tb_movement_sequencer.sv
// Directed frame-by-frame bench for movement_sequencer: move codes checked against a scoreboard,
// frame phase sequence, bird mode, overrun and reset behaviour checked with immediate assertions.
module tb_movement_sequencer;

  localparam int unsigned ESC = 3;
  localparam int unsigned BS  = 2;
  localparam int unsigned WD  = 64;

  localparam logic [3:0] C_HOLD  = 4'b0000;
  localparam logic [3:0] C_PRE   = 4'b0100;
  localparam logic [3:0] C_CLEAR = 4'b0001;
  localparam logic [3:0] C_LEFT  = 4'b0011;
  localparam logic [3:0] C_RIGHT = 4'b0010;
  localparam logic [3:0] C_DOWN  = 4'b0110;
  localparam logic [3:0] C_UP    = 4'b0111;
  localparam logic [3:0] C_DRAW  = 4'b0101;

  logic clk = 1'b0;
  logic reset_n, frame_tick, btn_left, btn_right, btn_down, btn_up, shot;
  logic fly, fall, frame_busy, overrun;
`ifdef WATCHDOG_EN
  logic wd_err;
`endif

  movement_sequencer_if dp();

  movement_sequencer #(.ESCAPE_FRAMES(ESC), .BIRD_STEPS(BS), .WD_CYCLES(WD)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .frame_tick (frame_tick),
    .btn_left   (btn_left),
    .btn_right  (btn_right),
    .btn_down   (btn_down),
    .btn_up     (btn_up),
    .shot       (shot),
    .dp         (dp.master),
    .fly        (fly),
    .fall       (fall),
    .frame_busy (frame_busy),
`ifdef WATCHDOG_EN
    .wd_err     (wd_err),
`endif
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  logic [4:0] sb[$];
  logic [4:0] exp_mv;
  logic m_xd, m_yd, m_fly, m_fall;
  int   m_esc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic is_move(input logic [3:0] c);
    return c inside {C_LEFT, C_RIGHT, C_DOWN, C_UP};
  endfunction

  // Every move-code cycle pops one expected {PorB, control}
  always @(negedge clk) begin
    if (reset_n && is_move(dp.control)) begin
      n_tests++;
      assert (sb.size() != 0) else begin
        n_fail++;
        $error("FAIL move_unexpected observed=%0h expected=none", {dp.PorB, dp.control});
      end
      if (sb.size() != 0) begin
        exp_mv = sb.pop_front();
        n_tests++;
        assert ({dp.PorB, dp.control} === exp_mv) else begin
          n_fail++;
          $error("FAIL move_code observed=%0h expected=%0h", {dp.PorB, dp.control}, exp_mv);
        end
      end
    end
  end

  // en_delay: >0 pulse enable on that cycle of each CLEAR/DRAW, 0 hold enable high, <0 never
  task automatic run_frame(input string tag, input logic [3:0] btns, input int en_delay,
                           input bit do_shot, input bit do_leave, input bit do_tick);
    logic signed [7:0] ys;
    logic [4:0] cur, prev;
    logic [4:0] ph_code [8];
    int         ph_len  [8];
    logic [3:0] ec;
    int         n_ph, cnt, len_exp;
    bit         done, exp_fall_shot;

    if (btns[0]) sb.push_back({1'b0, C_LEFT});
    if (btns[1]) sb.push_back({1'b0, C_RIGHT});
    if (btns[2]) sb.push_back({1'b0, C_DOWN});
    if (btns[3]) sb.push_back({1'b0, C_UP});
    if (do_shot && !m_fly && !m_fall) begin
      m_fall = 1'b1;
      m_esc  = 0;
    end
    exp_fall_shot = m_fall;
    ys = dp.yb;
    if (!m_fly && !m_fall) begin
      if (dp.xb <= 8'd2) m_xd = 1'b1; else if (dp.xb >= 8'd158) m_xd = 1'b0;
      if (ys <= 8'sd0) m_yd = 1'b1; else if (ys >= 8'sd117) m_yd = 1'b0;
      repeat (BS) begin
        sb.push_back({1'b1, m_xd ? C_RIGHT : C_LEFT});
        sb.push_back({1'b1, m_yd ? C_DOWN : C_UP});
      end
    end else if (m_fall) begin
      repeat (BS) sb.push_back({1'b1, C_DOWN});
    end else begin
      repeat (BS) sb.push_back({1'b1, C_UP});
    end
    if (do_leave) begin
      m_fly = 1'b0; m_fall = 1'b0; m_esc = 0;
    end else if (!m_fly && !m_fall) begin
      if (m_esc == int'(ESC) - 1) begin m_fly = 1'b1; m_esc = 0; end
      else m_esc++;
    end
    len_exp = (en_delay > 0) ? en_delay : (en_delay == 0) ? 2 : int'(WD);

    @(posedge clk) #1;
    {btn_up, btn_down, btn_right, btn_left} = btns;
    frame_tick = 1'b1;
    dp.enable  = (en_delay == 0);
    @(posedge clk) #1;
    frame_tick = 1'b0;

    prev = {1'b0, C_HOLD};
    cnt  = 0;
    n_ph = 0;
    done = 1'b0;
    for (int cyc = 0; cyc < 600 && !done; cyc++) begin
      @(negedge clk);
      cur = {dp.PorB, dp.control};
      if (cyc == 0) chk($sformatf("%s_busy", tag), 32'(frame_busy), 32'd1);
      if (shot) begin
        shot = 1'b0;
        chk($sformatf("%s_fall_after_shot", tag), 32'(fall), 32'(exp_fall_shot));
      end
      if (cur == prev) begin
        cnt++;
      end else begin
        if (!is_move(prev[3:0]) && prev[3:0] != C_HOLD) begin
          if (n_ph < 8) begin ph_code[n_ph] = prev; ph_len[n_ph] = cnt; end
          n_ph++;
        end
        cnt  = 1;
        prev = cur;
      end
      if (cur[3:0] == C_HOLD) begin
        done = 1'b1;
      end else begin
        if (en_delay > 0)
          dp.enable = (cur[3:0] == C_CLEAR || cur[3:0] == C_DRAW) && (cnt == en_delay);
        if (do_shot && cur == {1'b0, C_CLEAR} && cnt == 1) shot = 1'b1;
        frame_tick = do_tick && (cur == {1'b0, C_DRAW}) && (cnt == 2);
        dp.leave   = do_leave && (cur == {1'b1, C_DRAW});
      end
    end
    dp.enable = 1'b0; dp.leave = 1'b0; frame_tick = 1'b0; shot = 1'b0;
    {btn_up, btn_down, btn_right, btn_left} = 4'b0000;

    chk($sformatf("%s_completed", tag), 32'(done), 32'd1);
    chk($sformatf("%s_idle", tag), 32'(frame_busy), 32'd0);
    chk($sformatf("%s_moves_left", tag), 32'(sb.size()), 32'd0);
    sb.delete();
    chk($sformatf("%s_phase_count", tag), 32'(n_ph), 32'd6);
    for (int i = 0; i < 6; i++) begin
      ec = (i % 3 == 0) ? C_PRE : (i % 3 == 1) ? C_CLEAR : C_DRAW;
      if (i < n_ph) begin
        chk($sformatf("%s_ph%0d_code", tag, i), 32'(ph_code[i]), 32'({(i >= 3), ec}));
        chk($sformatf("%s_ph%0d_len", tag, i), 32'(ph_len[i]), 32'((i % 3 == 0) ? 1 : len_exp));
      end
    end
    chk($sformatf("%s_fly", tag), 32'(fly), 32'(m_fly));
    chk($sformatf("%s_fall", tag), 32'(fall), 32'(m_fall));
  endtask

  initial begin
    reset_n = 1'b0; frame_tick = 1'b0; shot = 1'b0;
    {btn_up, btn_down, btn_right, btn_left} = 4'b0000;
    dp.enable = 1'b0; dp.leave = 1'b0; dp.xb = 8'd80; dp.yb = 8'd50;
    m_xd = 1'b1; m_yd = 1'b0; m_fly = 1'b0; m_fall = 1'b0; m_esc = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_control", 32'(dp.control), 32'(C_HOLD));
    chk("rst_porb", 32'(dp.PorB), 32'd0);
    chk("rst_fly", 32'(fly), 32'd0);
    chk("rst_fall", 32'(fall), 32'd0);
    chk("rst_busy", 32'(frame_busy), 32'd0);
    chk("rst_overrun", 32'(overrun), 32'd0);
`ifdef WATCHDOG_EN
    chk("rst_wd_err", 32'(wd_err), 32'd0);
`endif
    reset_n = 1'b1;

    run_frame("t1_basic", 4'b0000, 4, 1'b0, 1'b0, 1'b0);
    chk("t1_overrun", 32'(overrun), 32'd0);
    run_frame("t2_left_up", 4'b1001, 4, 1'b0, 1'b0, 1'b0);
    dp.xb = 8'd158; dp.yb = 8'd0;
    run_frame("t3_edge_escape", 4'b0000, 3, 1'b0, 1'b0, 1'b0);
    dp.xb = 8'd1;
    run_frame("t4_fly_leave", 4'b1111, 0, 1'b1, 1'b1, 1'b0);
    dp.yb = 8'hFB;
    run_frame("t5_bounce_low", 4'b0110, 5, 1'b0, 1'b0, 1'b0);
    dp.xb = 8'd200;
    run_frame("t6_shot", 4'b0000, 4, 1'b1, 1'b0, 1'b0);
    run_frame("t7_fall_leave_tick", 4'b0010, 4, 1'b1, 1'b1, 1'b1);
    chk("t7_overrun", 32'(overrun), 32'd1);
    repeat (3) @(negedge clk);
    chk("t7_tick_ignored", 32'(frame_busy), 32'd0);
    dp.xb = 8'd158; dp.yb = 8'd117;
    run_frame("t8_bounce_high", 4'b0000, 4, 1'b0, 1'b0, 1'b0);
    chk("t8_overrun_sticky", 32'(overrun), 32'd1);

    @(posedge clk) #1;
    frame_tick = 1'b1;
    @(posedge clk) #1;
    frame_tick = 1'b0;
    repeat (3) @(negedge clk);
    chk("midrst_in_clear", 32'(dp.control), 32'(C_CLEAR));
    reset_n = 1'b0;
    #1;
    chk("midrst_control", 32'(dp.control), 32'(C_HOLD));
    chk("midrst_busy", 32'(frame_busy), 32'd0);
    chk("midrst_overrun", 32'(overrun), 32'd0);
    m_xd = 1'b1; m_yd = 1'b0; m_fly = 1'b0; m_fall = 1'b0; m_esc = 0;
    @(negedge clk);
    reset_n = 1'b1;
    dp.xb = 8'd80; dp.yb = 8'd50;
    run_frame("t9_after_reset", 4'b0000, 4, 1'b0, 1'b0, 1'b0);

`ifdef WATCHDOG_EN
    chk("t10_wd_err_before", 32'(wd_err), 32'd0);
    run_frame("t10_watchdog", 4'b0000, -1, 1'b0, 1'b0, 1'b0);
    chk("t10_wd_err", 32'(wd_err), 32'd1);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "simulation time limit");
  end

endmodule
